vga_scanout: RTL

- Display-refresh engine directly downstream of the display framebuffer memory.
- Framebuffer: 9600 x 32-bit words, 1 bit per pixel, 640x480, 20 words per line, big-endian pixel order.
- Generates 640x480@60 timing, drives the framebuffer word-read address, and serializes each 32-bit word into 32 pixels.
- Emits hsync, vsync, video_on and 12-bit RGB to the VGA DAC pins.

---
 rtl/vga_scanout.sv | 137 +++++++++++++
 1 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: 640x480@60 refresh engine. It generates the display timing,
// addresses the 1 bpp framebuffer one 32-bit word at a time and serializes
// each word MSB-first into 32 pixels on the RGB444 DAC pins.
// Optional build macro SCANOUT_FRAME_PULSE_EN adds a one-clock frame_pulse
// output at the start of vertical blanking.
module vga_scanout #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] displayAddr,
  input  logic [31:0] displayData,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [11:0] rgb
`ifdef SCANOUT_FRAME_PULSE_EN
  ,
  output logic        frame_pulse
`endif
);

  localparam int unsigned H_TOTAL        = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL        = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned WORDS_PER_LINE = H_ACTIVE / 32;
  localparam int unsigned DIV_W          = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_W            = $clog2(H_TOTAL);
  localparam int unsigned V_W            = $clog2(V_TOTAL);

  logic [DIV_W-1:0] div;
  logic [H_W-1:0]   h_cnt;
  logic [V_W-1:0]   v_cnt;
  logic [30:0]      shift_reg;

  logic pix_tick_c;
  logic h_last_c;
  logic v_last_c;
  logic active_c;
  logic load_c;
  logic pixel_c;
  logic hsync_c;
  logic vsync_c;

  // Pixel-rate strobe and counter decode
  always_comb begin
    pix_tick_c = (div == DIV_W'(CLK_DIV - 1));
    h_last_c   = (h_cnt == H_W'(H_TOTAL - 1));
    v_last_c   = (v_cnt == V_W'(V_TOTAL - 1));
    active_c   = (h_cnt < H_W'(H_ACTIVE)) && (v_cnt < V_W'(V_ACTIVE));
    load_c     = active_c && (h_cnt[4:0] == 5'd0);
    pixel_c    = load_c ? displayData[31] : shift_reg[30];
    hsync_c    = !((h_cnt >= H_W'(H_ACTIVE + H_FP)) &&
                   (h_cnt <  H_W'(H_ACTIVE + H_FP + H_SYNC)));
    vsync_c    = !((v_cnt >= V_W'(V_ACTIVE + V_FP)) &&
                   (v_cnt <  V_W'(V_ACTIVE + V_FP + V_SYNC)));
  end

  // Word address of the current 32-pixel group; zero while blanking
  always_comb begin
    displayAddr = '0;
    if (active_c) begin
      displayAddr = 32'(v_cnt) * 32'(WORDS_PER_LINE) + 32'(h_cnt >> 5);
    end
  end

  // Clock divider producing one pixel tick every CLK_DIV clocks
  always_ff @(posedge clk) begin
    if (rst) begin
      div <= '0;
    end else if (pix_tick_c) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  // Raster position counters
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick_c) begin
      if (h_last_c) begin
        h_cnt <= '0;
        v_cnt <= v_last_c ? '0 : v_cnt + V_W'(1);
      end else begin
        h_cnt <= h_cnt + H_W'(1);
      end
    end
  end

  // Serializer: load remaining 31 bits at a group start, shift otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
    end else if (pix_tick_c && active_c) begin
      shift_reg <= load_c ? displayData[30:0] : {shift_reg[29:0], 1'b0};
    end
  end

  // Output pipeline: one pixel of latency behind the counters
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
      rgb      <= 12'h000;
    end else if (pix_tick_c) begin
      hsync    <= hsync_c;
      vsync    <= vsync_c;
      video_on <= active_c;
      rgb      <= active_c ? (pixel_c ? FG_COLOR : BG_COLOR) : 12'h000;
    end
  end

`ifdef SCANOUT_FRAME_PULSE_EN
  // One-clock strobe as the raster enters vertical blanking
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_pulse <= 1'b0;
    end else begin
      frame_pulse <= pix_tick_c && h_last_c && (v_cnt == V_W'(V_ACTIVE - 1));
    end
  end
`endif

endmodule
